// File: rtl/t_toggle_decoder.sv
// Toggle-line event decoder: synchronises a remote T flip-flop output, turns each edge into a
// one-cycle pulse, counts events and buffers pending ones behind a valid/ready handshake.
module t_toggle_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tgl_in,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_ev_ready,
    output logic              o_ev_valid,
    output logic              o_ev_pulse,
    output logic              o_level,
    output logic [CNT_W-1:0]  o_ev_cnt,
    output logic [PEND_W-1:0] o_pend,
    output logic              o_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tgl_d;
    logic                   r_ev_pulse;
    logic [CNT_W-1:0]       r_ev_cnt;
    logic [PEND_W-1:0]      r_pend;
    logic                   r_ovf;

    logic w_level;
    logic w_edge;
    logic w_ev;
    logic w_ev_valid;
    logic w_pop;

    assign w_level    = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_level ^ r_tgl_d;
    assign w_ev       = w_edge & i_en & ~i_clr;
    // Valid depends on registered state only, so there is no ready-to-valid path.
    assign w_ev_valid = (r_pend != '0);
    assign w_pop      = w_ev_valid & i_ev_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= '0;
            r_tgl_d    <= 1'b0;
            r_ev_pulse <= 1'b0;
            r_ev_cnt   <= '0;
            r_pend     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_tgl_in};
            // tgl_d tracks level regardless of en/clr so re-enabling never sees a stale edge.
            r_tgl_d    <= w_level;
            r_ev_pulse <= w_ev;
            if (i_clr) begin
                r_ev_cnt <= '0;
                r_pend   <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_ev) begin
                    r_ev_cnt <= r_ev_cnt + CNT_ONE;
                end
                if (w_ev && !w_pop) begin
                    if (r_pend != PEND_MAX) begin
                        r_pend <= r_pend + PEND_ONE;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else if (!w_ev && w_pop) begin
                    r_pend <= r_pend - PEND_ONE;
                end
            end
        end
    end

    assign o_ev_valid = w_ev_valid;
    assign o_ev_pulse = r_ev_pulse;
    assign o_level    = w_level;
    assign o_ev_cnt   = r_ev_cnt;
    assign o_pend     = r_pend;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Bench for t_toggle_decoder: directed scenarios plus random traffic, checked against a
// sample-history reference model with a pulse scoreboard.
module tb_t_toggle_decoder;

    localparam int unsigned SS     = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PEND_W = 4;
    localparam int          PMAX   = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tgl = 1'b0;
    logic              en = 1'b1;
    logic              clr = 1'b0;
    logic              ready = 1'b0;
    logic              o_ev_valid;
    logic              o_ev_pulse;
    logic              o_level;
    logic [CNT_W-1:0]  o_ev_cnt;
    logic [PEND_W-1:0] o_pend;
    logic              o_ovf;

    t_toggle_decoder #(
        .SYNC_STAGES (SS),
        .CNT_W       (CNT_W),
        .PEND_W      (PEND_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tgl_in   (tgl),
        .i_en       (en),
        .i_clr      (clr),
        .i_ev_ready (ready),
        .o_ev_valid (o_ev_valid),
        .o_ev_pulse (o_ev_pulse),
        .o_level    (o_level),
        .o_ev_cnt   (o_ev_cnt),
        .o_pend     (o_pend),
        .o_ovf      (o_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [CNT_W-1:0] cnt;
        int               pend;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: h[j] is tgl_in as sampled j edges ago; an event is a change in the
    // line as seen SS edges late, gated by en/clr at the edge where it becomes visible.
    logic             h[0:7];
    logic [CNT_W-1:0] m_cnt = '0;
    int               m_pend = 0;
    logic             m_ovf = 1'b0;

    always @(posedge clk) begin
        logic m_ev;
        logic m_pop;
        #1;
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) h[j] = 1'b0;
            m_cnt  = '0;
            m_pend = 0;
            m_ovf  = 1'b0;
            sb_q.delete();
        end else begin
            for (int j = 7; j > 0; j--) h[j] = h[j-1];
            h[0] = tgl;
            m_ev  = (h[SS] != h[SS+1]) && en && !clr;
            m_pop = (m_pend != 0) && ready;
            if (clr) begin
                m_cnt  = '0;
                m_pend = 0;
                m_ovf  = 1'b0;
            end else begin
                if (m_ev) m_cnt = m_cnt + 1'b1;
                if (m_ev && !m_pop) begin
                    if (m_pend < PMAX) m_pend++;
                    else m_ovf = 1'b1;
                end else if (!m_ev && m_pop) begin
                    m_pend--;
                end
            end
            if (m_ev) sb_q.push_back('{cnt: m_cnt, pend: m_pend, ovf: m_ovf});
            chk("pulse", o_ev_pulse, m_ev);
            chk("level", o_level, h[SS-1]);
            chk("pend", o_pend, m_pend);
            chk("valid", o_ev_valid, m_pend != 0);
            chk("ovf", o_ovf, m_ovf);
            chk("cnt", o_ev_cnt, m_cnt);
        end
    end

    // Scoreboard monitor: consumes one expected record per presented pulse.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n && o_ev_pulse) begin
            if (sb_q.size() == 0) begin
                chk("sb_spurious_pulse", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_cnt", o_ev_cnt, e.cnt);
                chk("sb_pend", o_pend, e.pend);
                chk("sb_ovf", o_ovf, e.ovf);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggles(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tgl = ~tgl;
            cyc(gap);
        end
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        cyc(2);
        chk("rst_cnt", o_ev_cnt, 0);
        chk("rst_valid", o_ev_valid, 0);
        rst_n = 1'b1;
        cyc(2);

        // Single event: pulse timing checked per edge by the model.
        toggles(1, 6);
        chk("t1_cnt", o_ev_cnt, 1);
        chk("t1_pend", o_pend, 1);
        chk("t1_valid", o_ev_valid, 1);

        // Six events buffered, then drained.
        clr_pulse();
        toggles(6, 4);
        chk("t2_cnt", o_ev_cnt, 6);
        chk("t2_pend", o_pend, 6);
        ready = 1'b1;
        cyc(6);
        ready = 1'b0;
        chk("t2_drain_pend", o_pend, 0);
        chk("t2_drain_valid", o_ev_valid, 0);

        // Saturation and overflow, then clear.
        toggles(17, 4);
        chk("t3_pend", o_pend, PMAX);
        chk("t3_ovf", o_ovf, 1);
        chk("t3_cnt", o_ev_cnt, 6 + 17);
        clr_pulse();
        chk("t3_clr_cnt", o_ev_cnt, 0);
        chk("t3_clr_pend", o_pend, 0);
        chk("t3_clr_ovf", o_ovf, 0);

        // Full buffer: event lands in the same cycle as a pop.
        toggles(15, 4);
        chk("t4_full", o_pend, PMAX);
        tgl = ~tgl;
        cyc(2);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        cyc(3);
        chk("t4_pend", o_pend, PMAX);
        chk("t4_ovf", o_ovf, 0);
        chk("t4_cnt", o_ev_cnt, 16);

        // Disabled: edges ignored, level still tracks.
        clr_pulse();
        en = 1'b0;
        toggles(3, 4);
        cyc(4);
        en = 1'b1;
        cyc(6);
        chk("t5_cnt", o_ev_cnt, 0);
        chk("t5_level", o_level, tgl);

        // Counter wrap.
        clr_pulse();
        ready = 1'b1;
        toggles(255, 2);
        cyc(4);
        chk("t6_cnt255", o_ev_cnt, 255);
        toggles(1, 6);
        chk("t6_wrap", o_ev_cnt, 0);
        chk("t6_wrap_ovf", o_ovf, 0);

        // Asynchronous reset mid-burst, between clock edges.
        ready = 1'b0;
        toggles(5, 2);
        tgl = ~tgl;
        #3;
        rst_n = 1'b0;
        tgl = 1'b0;
        #1;
        chk("arst_pulse", o_ev_pulse, 0);
        chk("arst_level", o_level, 0);
        chk("arst_cnt", o_ev_cnt, 0);
        chk("arst_pend", o_pend, 0);
        chk("arst_valid", o_ev_valid, 0);
        chk("arst_ovf", o_ovf, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        // Random traffic.
        gap = 2;
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            ready = ($urandom_range(0, 2) == 0);
            if (--gap == 0) begin
                tgl = ~tgl;
                gap = $urandom_range(2, 6);
            end
            cyc(1);
        end
        en = 1'b1;
        clr = 1'b0;
        cyc(6);
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
